// File: rtl/spi_engine_pkg.sv
// Shared definitions for the SPI Engine execution lane handling: FSM states,
// lane count limits and the word-length clamp used by the lane packers.
package spi_engine_pkg;

  localparam int SPI_ENGINE_MAX_LANES  = 8;
  localparam int SPI_ENGINE_LANE_IDX_W = $clog2(SPI_ENGINE_MAX_LANES);

  typedef enum logic {
    SPI_ENGINE_IDLE = 1'b0,
    SPI_ENGINE_SEND = 1'b1
  } spi_engine_state_e;

  // A length of zero or one wider than the lane means "use the full lane".
  function automatic int spi_engine_eff_len(input logic [7:0] word_length,
                                            input int data_width);
    if (word_length == 8'd0 || int'(word_length) > data_width) begin
      return data_width;
    end
    return int'(word_length);
  endfunction

endpackage

// File: rtl/spi_engine_lane_next_active.sv
// Combinational lane scanner: finds the next set mask bit strictly above the
// current index, and the lowest set mask bit overall.
module spi_engine_lane_next_active
  import spi_engine_pkg::*;
(
  input  logic [SPI_ENGINE_MAX_LANES-1:0]  mask,
  input  logic [SPI_ENGINE_LANE_IDX_W-1:0] cur_idx,
  output logic [SPI_ENGINE_LANE_IDX_W-1:0] next_idx,
  output logic                             next_found,
  output logic [SPI_ENGINE_LANE_IDX_W-1:0] lowest_idx
);

  // Scanning downward lets the lowest qualifying bit win by overwriting.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    lowest_idx = '0;
    for (int i = SPI_ENGINE_MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_idx = SPI_ENGINE_LANE_IDX_W'(i);
        if (i > int'(cur_idx)) begin
          next_idx   = SPI_ENGINE_LANE_IDX_W'(i);
          next_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_engine_execution_sdi_data_disassemble.sv
// Splits one captured multi-lane SDI word into per-lane beats, lowest active
// lane first, each lane masked to the active word length.
module spi_engine_execution_sdi_data_disassemble
  import spi_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_OF_SDI = 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_OF_SDI*DATA_WIDTH-1:0]   sdi_word,
  input  logic                               sdi_word_valid,
  output logic                               sdi_word_ready,
  input  logic [7:0]                         lane_mask,
  input  logic [7:0]                         word_length,
  output logic [DATA_WIDTH-1:0]              sdi_data,
  output logic                               sdi_data_valid,
  input  logic                               sdi_data_ready,
  output logic                               sdi_data_last,
  output logic                               word_dropped,
  output logic                               busy
);

  localparam int WORD_W = NUM_OF_SDI * DATA_WIDTH;

  spi_engine_state_e                  state_q, state_d;
  logic [WORD_W-1:0]                  word_q, word_d;
  logic [SPI_ENGINE_MAX_LANES-1:0]    mask_q, mask_d;
  logic [SPI_ENGINE_LANE_IDX_W-1:0]   idx_q, idx_d;
  logic                               dropped_q, dropped_d;

  logic [SPI_ENGINE_MAX_LANES-1:0]    in_mask;
  logic [DATA_WIDTH-1:0]              len_bits;
  logic [WORD_W-1:0]                  word_masked;
  logic [DATA_WIDTH-1:0]              lanes_ext [SPI_ENGINE_MAX_LANES];
  int                                 eff_len;

  logic [SPI_ENGINE_LANE_IDX_W-1:0]   next_idx;
  logic                               next_found;
  logic [SPI_ENGINE_LANE_IDX_W-1:0]   cur_lowest_unused;
  logic [SPI_ENGINE_LANE_IDX_W-1:0]   in_next_unused;
  logic                               in_found_unused;
  logic [SPI_ENGINE_LANE_IDX_W-1:0]   in_lowest;

  logic                               beat_last;
  logic                               accept;

  spi_engine_lane_next_active u_cur_scan (
    .mask       (mask_q),
    .cur_idx    (idx_q),
    .next_idx   (next_idx),
    .next_found (next_found),
    .lowest_idx (cur_lowest_unused)
  );

  spi_engine_lane_next_active u_in_scan (
    .mask       (in_mask),
    .cur_idx    (idx_q),
    .next_idx   (in_next_unused),
    .next_found (in_found_unused),
    .lowest_idx (in_lowest)
  );

  // Incoming word is trimmed to existing lanes and to the active length
  // before storage, so the send path only has to select a lane.
  always_comb begin
    in_mask     = '0;
    len_bits    = '0;
    word_masked = '0;
    eff_len     = spi_engine_eff_len(word_length, DATA_WIDTH);
    for (int i = 0; i < SPI_ENGINE_MAX_LANES; i++) begin
      in_mask[i] = lane_mask[i] && (i < NUM_OF_SDI);
    end
    for (int b = 0; b < DATA_WIDTH; b++) begin
      len_bits[b] = (b < eff_len);
    end
    for (int k = 0; k < NUM_OF_SDI; k++) begin
      word_masked[k*DATA_WIDTH +: DATA_WIDTH] = sdi_word[k*DATA_WIDTH +: DATA_WIDTH] & len_bits;
    end
  end

  always_comb begin
    for (int k = 0; k < SPI_ENGINE_MAX_LANES; k++) begin
      lanes_ext[k] = '0;
    end
    for (int k = 0; k < NUM_OF_SDI; k++) begin
      lanes_ext[k] = word_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign beat_last      = (state_q == SPI_ENGINE_SEND) && !next_found;
  assign sdi_data_valid = (state_q == SPI_ENGINE_SEND);
  assign sdi_data       = sdi_data_valid ? lanes_ext[idx_q] : '0;
  assign sdi_data_last  = beat_last;
  assign sdi_word_ready = (state_q == SPI_ENGINE_IDLE) || (beat_last && sdi_data_ready);
  assign busy           = sdi_data_valid;
  assign word_dropped   = dropped_q;
  assign accept         = sdi_word_valid && sdi_word_ready;

  // A word accepted on the last-beat edge overrides the return to IDLE.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    dropped_d = 1'b0;
    if (state_q == SPI_ENGINE_SEND && sdi_data_ready) begin
      if (next_found) begin
        idx_d = next_idx;
      end else begin
        state_d = SPI_ENGINE_IDLE;
      end
    end
    if (accept) begin
      word_d = word_masked;
      mask_d = in_mask;
      if (in_mask != '0) begin
        state_d = SPI_ENGINE_SEND;
        idx_d   = in_lowest;
      end else begin
        state_d   = SPI_ENGINE_IDLE;
        dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= SPI_ENGINE_IDLE;
      word_q    <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_spi_engine_execution_sdi_data_disassemble.sv
// Scoreboard bench for the SDI lane disassembler: directed scenarios followed
// by randomized words and backpressure, checked against a lane-list model.
module tb_spi_engine_execution_sdi_data_disassemble;

  localparam int DW   = 8;
  localparam int NSDI = 4;
  localparam int WW   = NSDI * DW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [WW-1:0] sdi_word = '0;
  logic          sdi_word_valid = 1'b0;
  logic          sdi_word_ready;
  logic [7:0]    lane_mask = '0;
  logic [7:0]    word_length = '0;
  logic [DW-1:0] sdi_data;
  logic          sdi_data_valid;
  logic          sdi_data_ready = 1'b1;
  logic          sdi_data_last;
  logic          word_dropped;
  logic          busy;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      sb_q[$];
  int         exp_drops = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         hold_low = 0;
  bit         ready_random = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  spi_engine_execution_sdi_data_disassemble #(
    .DATA_WIDTH (DW),
    .NUM_OF_SDI (NSDI)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .sdi_word       (sdi_word),
    .sdi_word_valid (sdi_word_valid),
    .sdi_word_ready (sdi_word_ready),
    .lane_mask      (lane_mask),
    .word_length    (word_length),
    .sdi_data       (sdi_data),
    .sdi_data_valid (sdi_data_valid),
    .sdi_data_ready (sdi_data_ready),
    .sdi_data_last  (sdi_data_last),
    .word_dropped   (word_dropped),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Reference model: list the enabled existing lanes low to high, each lane
  // value shifted down and cut to the clamped length.
  task automatic push_expected(input logic [WW-1:0] word, input logic [7:0] mask, input logic [7:0] wl);
    int         len;
    int         top;
    logic [7:0] m;
    beat_t      b;
    len = (wl == 0 || wl > DW) ? DW : int'(wl);
    m   = mask & 8'((1 << NSDI) - 1);
    top = -1;
    for (int k = 0; k < NSDI; k++) if (m[k]) top = k;
    if (top < 0) begin
      exp_drops++;
    end else begin
      for (int k = 0; k < NSDI; k++) begin
        if (m[k]) begin
          b.data = 8'((word >> (8 * k)) & ((32'd1 << len) - 32'd1));
          b.last = (k == top);
          sb_q.push_back(b);
        end
      end
    end
  endtask

  // Presents one word, returns after the accepting edge with the number of
  // cycles it was offered; mask/length are scrambled afterwards on purpose.
  task automatic apply_stimulus(input logic [WW-1:0] word, input logic [7:0] mask,
                                input logic [7:0] wl, output int waited);
    bit accepted;
    sdi_word       = word;
    lane_mask      = mask;
    word_length    = wl;
    sdi_word_valid = 1'b1;
    waited         = 0;
    accepted       = 1'b0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      waited++;
      if (sdi_word_ready) begin
        push_expected(word, mask, wl);
        accepted = 1'b1;
      end
    end
    if (!accepted) report_fail("accept_timeout");
    @(posedge clk);
    #2;
    sdi_word_valid = 1'b0;
    sdi_word       = WW'($urandom);
    lane_mask      = 8'($urandom);
    word_length    = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) report_fail("drain_timeout");
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0) begin
        sdi_data_ready = 1'b0;
        hold_low--;
      end else if (ready_random) begin
        sdi_data_ready = ($urandom_range(0, 3) != 0);
      end else begin
        sdi_data_ready = 1'b1;
      end
    end
  end

  // Monitor: consumes expected beats on handshakes, checks stall stability
  // and accounts for dropped-word pulses.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_output("stall_valid", sdi_data_valid, 1);
          check_output("stall_data", sdi_data, prev_data);
          check_output("stall_last", sdi_data_last, prev_last);
        end
        if (word_dropped) begin
          if (exp_drops == 0) report_fail("unexpected_drop");
          else exp_drops--;
        end
        if (sdi_data_valid) begin
          if (sb_q.size() == 0) begin
            report_fail("unexpected_beat");
          end else if (sdi_data_ready) begin
            e = sb_q.pop_front();
            check_output("beat_data", sdi_data, e.data);
            check_output("beat_last", sdi_data_last, e.last);
          end
        end
        prev_stall = sdi_data_valid && !sdi_data_ready;
        prev_data  = sdi_data;
        prev_last  = sdi_data_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    int w2;
    logic [7:0] m;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_output("rst_valid", sdi_data_valid, 0);
    check_output("rst_ready", sdi_word_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_last", sdi_data_last, 0);
    check_output("rst_data", sdi_data, 0);
    check_output("rst_dropped", word_dropped, 0);
    resetn = 1'b1;
    @(posedge clk);
    #2;

    $display("[TB] all four lanes");
    apply_stimulus(32'h44332211, 8'h0F, 8'd8, w);
    check_output("lat_valid", sdi_data_valid, 1);
    check_output("lat_data", sdi_data, 8'h11);
    check_output("lat_last", sdi_data_last, 0);
    wait_drain();

    $display("[TB] sparse mask");
    apply_stimulus(32'h44332211, 8'h05, 8'd8, w);
    check_output("sparse_first", sdi_data, 8'h11);
    @(posedge clk);
    #2;
    check_output("sparse_second", sdi_data, 8'h33);
    check_output("sparse_last", sdi_data_last, 1);
    wait_drain();

    $display("[TB] single lane, short length");
    apply_stimulus(32'hFFFFFFFF, 8'h02, 8'd5, w);
    check_output("single_data", sdi_data, 8'h1F);
    check_output("single_last", sdi_data_last, 1);
    check_output("single_busy", busy, 1);
    @(posedge clk);
    #2;
    check_output("single_busy_drop", busy, 0);
    wait_drain();

    $display("[TB] backpressure");
    hold_low = 3;
    apply_stimulus(32'h44332211, 8'h0F, 8'd8, w);
    check_output("bp_hold0", sdi_data, 8'h11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check_output("bp_hold", sdi_data, 8'h11);
    end
    @(posedge clk);
    #2;
    check_output("bp_next", sdi_data, 8'h22);
    wait_drain();

    $display("[TB] mask with no existing lane");
    apply_stimulus(32'h12345678, 8'hF0, 8'd8, w);
    check_output("drop_pulse", word_dropped, 1);
    check_output("drop_valid", sdi_data_valid, 0);
    check_output("drop_ready", sdi_word_ready, 1);
    @(posedge clk);
    #2;
    check_output("drop_pulse_end", word_dropped, 0);
    wait_drain();

    $display("[TB] back-to-back words then reset");
    apply_stimulus(32'h44332211, 8'h0F, 8'd8, w);
    apply_stimulus(32'h88776655, 8'h0F, 8'd8, w2);
    check_output("b2b_gap", w2, 4);
    @(posedge clk);
    #2;
    check_output("b2b_beat1", sdi_data, 8'h66);
    resetn = 1'b0;
    #1;
    check_output("arst_valid", sdi_data_valid, 0);
    check_output("arst_ready", sdi_word_ready, 1);
    check_output("arst_busy", busy, 0);
    check_output("arst_data", sdi_data, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check_output("post_rst_valid", sdi_data_valid, 0);

    $display("[TB] randomized words");
    ready_random = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
      m = 8'($urandom);
      if ($urandom_range(0, 7) == 0) m = m & 8'hF0;
      apply_stimulus(WW'($urandom), m, 8'($urandom_range(0, 12)), w);
    end
    wait_drain();
    ready_random = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_output("drops_pending", exp_drops, 0);
    check_output("beats_pending", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_engine_execution_sdi_data_disassemble.md
# spi_engine_execution_sdi_data_disassemble

Receive-side counterpart of the SDO lane assembler in the SPI Engine execution unit. It takes one captured multi-lane SDI word from the shift register, keeps only the lanes enabled in the lane mask, and masks each lane to the active word length. It then emits the lanes one per beat, lowest lane first, on a single DATA_WIDTH valid/ready stream toward the SDI FIFO. It sits between the execution shift register and the `sdi_data` output interface.

## Interface
- `DATA_WIDTH`, 8: bits per lane word.
- `NUM_OF_SDI`, 1: number of SDI lanes (1..8).
- `clk`  in  1  : the single clock.
- `resetn`  in  1  : reset, asynchronous and active-low.
- `sdi_word`  in  NUM_OF_SDI*DATA_WIDTH  : captured word; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], right-aligned.
- `sdi_word_valid`  in  1  : captured word is available.
- `sdi_word_ready`  out  1  : block can accept a word.
- `lane_mask`  in  8  : active lanes; sampled with the word; bits >= NUM_OF_SDI are ignored.
- `word_length`  in  8  : valid bits per lane; sampled with the word; 0 or > DATA_WIDTH is treated as DATA_WIDTH.
- `sdi_data`  out  DATA_WIDTH  : lane data beat.
- `sdi_data_valid`  out  1  : beat valid.
- `sdi_data_ready`  in  1  : downstream accepts the beat.
- `sdi_data_last`  out  1  : beat is the highest active lane of the word.
- `word_dropped`  out  1  : one-cycle pulse when an accepted word has no active lane.
- `busy`  out  1  : a word is buffered and not fully emitted.

## Operation
- Input accept: on a rising edge with `sdi_word_valid && sdi_word_ready`, latch `sdi_word`, `lane_mask & ((1<<NUM_OF_SDI)-1)` and the effective length.
- Length masking: each stored lane is ANDed with `(1<<len)-1`. Upper bits are zero.
- FSM has two states.
  - IDLE: `sdi_word_ready`=1.
    - On accept with a non-zero effective mask, go to SEND. The lane index becomes the lowest set mask bit.
    - On accept with a zero mask, pulse `word_dropped` and stay in IDLE.
  - SEND: `sdi_data_valid`=1 and `sdi_data` = the masked word of the current lane. `sdi_data_last`=1 when no higher mask bit is set.
    - On a beat handshake that is not last, the lane index moves to the next set mask bit above the current one. Inactive lanes are skipped with zero bubble cycles.
    - On a last-beat handshake, go to IDLE. If a new word is accepted on the same edge, load it and stay in SEND (or go to IDLE with `word_dropped` if its mask is zero).
- `sdi_word_ready` = (state==IDLE) or (state==SEND && last && `sdi_data_ready`). This is combinational from `sdi_data_ready`.
- `busy` = (state==SEND).

## Timing
- Reset values: `sdi_data`=0, `sdi_data_valid`=0, `sdi_data_last`=0, `word_dropped`=0, `busy`=0, `sdi_word_ready`=1, state=IDLE, lane index=0.
- Latency: word accepted at edge N → first beat valid in the cycle after edge N.
- Throughput: one beat per cycle while `sdi_data_ready`=1. Words stream back-to-back with no idle cycle.
- Backpressure: while `sdi_data_valid && !sdi_data_ready`, `sdi_data`, `sdi_data_last` and the lane index hold stable.
- A new `lane_mask`/`word_length` applied mid-SEND has no effect on the buffered word.
- Reset asserted mid-SEND: outputs go to reset values immediately (asynchronously) and the buffered word is discarded. No beat is produced after deassertion until a new word is accepted.
- Single active lane: the first beat carries `sdi_data_last`=1.

## Structure
- Shared package/include `spi_engine_pkg`:
  - FSM state encodings (IDLE, SEND).
  - `SPI_ENGINE_MAX_LANES`=8.
- Sub-module `spi_engine_lane_next_active` is combinational.
  - Inputs: 8-bit mask and current index.
  - Outputs: next set index strictly above current, a found flag, and the lowest set index.
  - The same module is reusable by the SDO assembler.

## Test plan
All scenarios use DATA_WIDTH=8 and NUM_OF_SDI=4.
- Mask 0xF, word 0x44332211, length 8, ready held high → beats 0x11, 0x22, 0x33, 0x44 on the four cycles after accept. `last` is asserted only on 0x44.
- Mask 0x5, same word → beats 0x11 then 0x33 (last) on consecutive cycles. Lanes 1 and 3 are skipped with no bubble.
- Mask 0x2, word 0xFFFFFFFF, length 5 → a single beat 0x1F with `last`=1. `busy` drops the next cycle.
- Mask 0xF, ready low for 3 cycles after the first valid → `sdi_data`=0x11 is held for 3 cycles, then 0x22..0x44 follow.
- Mask 0xF0 (all bits above NUM_OF_SDI) → `word_dropped` pulses for one cycle, no `sdi_data_valid`, and `sdi_word_ready` stays 1.
- Two words presented back-to-back: the second is accepted on the first word's last beat with no gap. Reset is asserted during the second word's second beat → valid=0 and ready=1 immediately, and no stale beats appear after release.
